// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the parallel ADC capture block: the power/run state
// encoding and the default values of the main build parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_pkg;

  // Power/run sequencing of the external ADC.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,  // ADC powered down, conversion clock parked low
    ST_WAKE = 2'd1,  // ADC powered and clocked, samples not yet trusted
    ST_RUN  = 2'd2   // samples captured and decimated
  } adc_state_e;

  localparam int DEF_DATA_W      = 7;
  localparam int DEF_CLK_DIV     = 2;
  localparam int DEF_WAKE_CYCLES = 64;
  localparam int DEF_DEC_LOG2    = 0;
  localparam int MAX_DEC_LOG2    = 4;

endpackage : adc_pkg

// File: rtl/adc_clk_gen.sv
// -----------------------------------------------------------------------------
// adc_clk_gen
// Divides the system clock down to the ADC conversion clock and marks the
// last high cycle of each ADC period, which is where the parallel bus is
// stable and gets sampled.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   run      in   1 while the ADC is powered (clock toggles)
//   halt     in   1 when the ADC is about to be powered down; the phase
//                 counter is parked at 0 on the following edge
//   adc_clk  out  conversion clock: high for the first CLK_DIV/2 phases
//   capture  out  1 on the last high phase of every ADC period
// -----------------------------------------------------------------------------
module adc_clk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic halt,
  output logic adc_clk,
  output logic capture
);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $fatal(1, "adc_clk_gen: CLK_DIV must be even and at least 2");
  end

  localparam int PH_W = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0] PH_CAP  = PH_W'(CLK_DIV / 2 - 1);

  logic [PH_W-1:0] phase;

  // Parking the counter on 'halt' (not just '!run') makes it read 0 from the
  // very first powered-down cycle, so every power-up starts a fresh period.
  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge values of its neighbours; a blocking = here would create
  // simulation/synthesis ordering mismatches.
  always_ff @(posedge clk) begin
    if (rst || !run || halt) begin
      phase <= '0;
    end else if (phase == PH_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign adc_clk = run && (phase < PH_HALF);
  assign capture = run && (phase == PH_CAP);

endmodule : adc_clk_gen

// File: rtl/adc_par_capture.sv
// -----------------------------------------------------------------------------
// adc_par_capture
// Powers and clocks an external parallel-output ADC, waits out its wake-up
// time, samples its bus once per conversion clock, optionally converts
// offset-binary to two's complement, boxcar-sums 2^DEC_LOG2 samples and
// presents each sum on a valid/ready output with a sticky drop flag.
//
// Ports
//   i_sysclk_40     in   system clock (only clock)
//   i_rst           in   synchronous, active-high reset
//   i_enable        in   level: 1 = run the ADC, 0 = power it down
//   i_adc_data      in   ADC parallel bus, DATA_W bits
//   o_adc_pwrdn     out  1 while the ADC is powered down
//   o_adc_clk       out  ADC conversion clock
//   o_data          out  decimated sum, DATA_W+DEC_LOG2 bits
//   o_valid         out  o_data holds an untaken result
//   i_ready         in   consumer accepts o_data when o_valid is also 1
//   o_overflow      out  sticky: a result arrived while one was still held
//   i_clr_overflow  in   1-cycle pulse clearing o_overflow
//   o_running       out  1 while samples are being accepted
// -----------------------------------------------------------------------------
module adc_par_capture
  import adc_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int DEC_LOG2    = DEF_DEC_LOG2,
  parameter int TWOS_COMP   = 0
) (
  input  logic                       i_sysclk_40,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic [DATA_W-1:0]          i_adc_data,
  output logic                       o_adc_pwrdn,
  output logic                       o_adc_clk,
  output logic [DATA_W+DEC_LOG2-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_overflow,
  input  logic                       i_clr_overflow,
  output logic                       o_running
);

  if (DEC_LOG2 < 0 || DEC_LOG2 > MAX_DEC_LOG2) begin : g_bad_dec_log2
    $fatal(1, "adc_par_capture: DEC_LOG2 must be in 0..4");
  end

  if (WAKE_CYCLES < 1) begin : g_bad_wake_cycles
    $fatal(1, "adc_par_capture: WAKE_CYCLES must be at least 1");
  end

  localparam int ACC_W       = DATA_W + DEC_LOG2;
  localparam int NUM_SAMPLES = 1 << DEC_LOG2;
  localparam int CNT_W       = DEC_LOG2 + 1;
  localparam int WAKE_W      = $clog2(WAKE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

  // XOR mask that flips the sample MSB (offset-binary -> two's complement).
  localparam logic [DATA_W-1:0] MSB_FLIP =
    (TWOS_COMP != 0) ? (DATA_W'(1) << (DATA_W - 1)) : '0;

  // ---------------------------------------------------------------------------
  // Power / run sequencing
  // ---------------------------------------------------------------------------
  adc_state_e        state;
  adc_state_e        state_next;
  logic [WAKE_W-1:0] wake_cnt;

  // NOTE: every signal assigned in an always_comb gets a default on the first
  // line; a path that leaves it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_OFF: begin
        if (i_enable) state_next = ST_WAKE;
      end
      ST_WAKE: begin
        if (!i_enable)                  state_next = ST_OFF;
        else if (wake_cnt == WAKE_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!i_enable) state_next = ST_OFF;
      end
      default: state_next = ST_OFF;
    endcase
  end

  // wake_cnt is 0 on the first WAKE cycle, so WAKE lasts exactly
  // WAKE_CYCLES cycles and restarts in full after any power-down.
  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      state    <= ST_OFF;
      wake_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_WAKE && state_next == ST_WAKE) begin
        wake_cnt <= wake_cnt + 1'b1;
      end else begin
        wake_cnt <= '0;
      end
    end
  end

  assign o_adc_pwrdn = (state == ST_OFF);
  assign o_running   = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Conversion clock and capture strobe
  // ---------------------------------------------------------------------------
  logic capture_strobe;

  adc_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (i_sysclk_40),
    .rst     (i_rst),
    .run     (state != ST_OFF),
    .halt    (!i_enable),
    .adc_clk (o_adc_clk),
    .capture (capture_strobe)
  );

  // WAKE-period strobes still occur but are ignored here.
  logic capture_run;
  assign capture_run = capture_strobe && (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Capture register: one cycle between the bus sample and the adder
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sample_q;
  logic              sample_vld;
  logic [ACC_W-1:0]  sample_ext;

  // NOTE: the datapath registers are reset along with the control state, so
  // nothing observable after reset depends on what was captured before it;
  // there is no storage array here that would need to be left unreset.
  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      sample_q   <= '0;
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= capture_run;
      if (capture_run) begin
        sample_q <= i_adc_data ^ MSB_FLIP;
      end
    end
  end

  // Signed samples are sign-extended so the modular sum in ACC_W bits is the
  // exact signed total; unsigned samples are zero-extended.
  always_comb begin
    if (TWOS_COMP != 0) begin
      sample_ext = ACC_W'($signed(sample_q));
    end else begin
      sample_ext = ACC_W'(sample_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Boxcar accumulator
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             result_ready;

  assign sum = acc + sample_ext;

  // A sample still in flight when RUN ends is discarded with the partial sum.
  assign result_ready = sample_vld && (state == ST_RUN) && (cnt == CNT_LAST);

  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (state != ST_RUN) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_vld) begin
      if (cnt == CNT_LAST) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  logic out_free;
  logic drop;

  // The slot is free if empty or being taken this very cycle.
  assign out_free = !o_valid || i_ready;
  assign drop     = result_ready && !out_free;

  always_ff @(posedge i_sysclk_40) begin
    if (i_rst) begin
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (result_ready && out_free) begin
        o_data  <= sum;
        o_valid <= 1'b1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clr_overflow) begin
        o_overflow <= 1'b0;
      end
    end
  end

endmodule : adc_par_capture

// File: tb/tb_adc_par_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_par_capture
// Directed bench for adc_par_capture. Three instances cover the build
// variants: A = all defaults, B = DEC_LOG2=2/CLK_DIV=4/WAKE_CYCLES=8,
// C = TWOS_COMP=1/WAKE_CYCLES=4. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, so "k" below counts the
// rising edges since the enable was raised.
// -----------------------------------------------------------------------------
module tb_adc_par_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // ---------------- instance A: defaults ----------------
  logic       en_a = 1'b0, ready_a = 1'b0, clr_a = 1'b0;
  logic [6:0] din_a = '0;
  logic       pwrdn_a, aclk_a, valid_a, ovf_a, run_a;
  logic [6:0] dout_a;

  adc_par_capture u_dut_a (
    .i_sysclk_40    (clk),
    .i_rst          (rst),
    .i_enable       (en_a),
    .i_adc_data     (din_a),
    .o_adc_pwrdn    (pwrdn_a),
    .o_adc_clk      (aclk_a),
    .o_data         (dout_a),
    .o_valid        (valid_a),
    .i_ready        (ready_a),
    .o_overflow     (ovf_a),
    .i_clr_overflow (clr_a),
    .o_running      (run_a)
  );

  // ---------------- instance B: decimate by 4 ----------------
  logic       en_b = 1'b0, ready_b = 1'b0, clr_b = 1'b0;
  logic [6:0] din_b = '0;
  logic       pwrdn_b, aclk_b, valid_b, ovf_b, run_b;
  logic [8:0] dout_b;

  adc_par_capture #(
    .CLK_DIV     (4),
    .WAKE_CYCLES (8),
    .DEC_LOG2    (2)
  ) u_dut_b (
    .i_sysclk_40    (clk),
    .i_rst          (rst),
    .i_enable       (en_b),
    .i_adc_data     (din_b),
    .o_adc_pwrdn    (pwrdn_b),
    .o_adc_clk      (aclk_b),
    .o_data         (dout_b),
    .o_valid        (valid_b),
    .i_ready        (ready_b),
    .o_overflow     (ovf_b),
    .i_clr_overflow (clr_b),
    .o_running      (run_b)
  );

  // ---------------- instance C: two's complement ----------------
  logic       en_c = 1'b0, ready_c = 1'b0, clr_c = 1'b0;
  logic [6:0] din_c = '0;
  logic       pwrdn_c, aclk_c, valid_c, ovf_c, run_c;
  logic [6:0] dout_c;

  adc_par_capture #(
    .WAKE_CYCLES (4),
    .TWOS_COMP   (1)
  ) u_dut_c (
    .i_sysclk_40    (clk),
    .i_rst          (rst),
    .i_enable       (en_c),
    .i_adc_data     (din_c),
    .o_adc_pwrdn    (pwrdn_c),
    .o_adc_clk      (aclk_c),
    .o_data         (dout_c),
    .o_valid        (valid_c),
    .i_ready        (ready_c),
    .o_overflow     (ovf_c),
    .i_clr_overflow (clr_c),
    .o_running      (run_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks_total++; if (pwrdn_a !== 1'b1) $display("FAIL reset_pwrdn_a got=%b exp=1", pwrdn_a); else checks_passed++;
    checks_total++; if (aclk_a !== 1'b0) $display("FAIL reset_adc_clk_a got=%b exp=0", aclk_a); else checks_passed++;
    checks_total++; if (valid_a !== 1'b0) $display("FAIL reset_valid_a got=%b exp=0", valid_a); else checks_passed++;
    checks_total++; if (dout_a !== 7'h00) $display("FAIL reset_data_a got=%h exp=00", dout_a); else checks_passed++;
    checks_total++; if (ovf_a !== 1'b0) $display("FAIL reset_overflow_a got=%b exp=0", ovf_a); else checks_passed++;
    checks_total++; if (run_a !== 1'b0) $display("FAIL reset_running_a got=%b exp=0", run_a); else checks_passed++;
    checks_total++; if (pwrdn_b !== 1'b1) $display("FAIL reset_pwrdn_b got=%b exp=1", pwrdn_b); else checks_passed++;
    checks_total++; if (dout_b !== 9'h000) $display("FAIL reset_data_b got=%h exp=000", dout_b); else checks_passed++;
    checks_total++; if (aclk_c !== 1'b0) $display("FAIL reset_adc_clk_c got=%b exp=0", aclk_c); else checks_passed++;
    rst = 1'b0;
    tick();
    checks_total++; if (pwrdn_a !== 1'b1) $display("FAIL idle_pwrdn_a got=%b exp=1", pwrdn_a); else checks_passed++;
  endtask

  // ---------------------------------------------------------------------------
  // C: wake 4 cycles, RUN from k=5, captures on odd k, result 2 edges later.
  task automatic test_twos_comp();
    en_c = 1'b1; ready_c = 1'b1; din_c = 7'h00;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 6) din_c = 7'h7F;
      if (k == 7) begin
        checks_total++; if (valid_c !== 1'b1) $display("FAIL tc_zero_valid got=%b exp=1", valid_c); else checks_passed++;
        checks_total++; if (dout_c !== 7'h40) $display("FAIL tc_zero_data got=%h exp=40", dout_c); else checks_passed++;
      end
      if (k == 9) begin
        checks_total++; if (valid_c !== 1'b1) $display("FAIL tc_max_valid got=%b exp=1", valid_c); else checks_passed++;
        checks_total++; if (dout_c !== 7'h3F) $display("FAIL tc_max_data got=%h exp=3f", dout_c); else checks_passed++;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // B from OFF: WAKE k=1..8, RUN from k=9, phase=(k-1)%4, captures in the
  // cycles after k=10,14,18,22; the 4-sample sum is valid after k=24.
  // WAKE samples carry 7F, which must never show up in the sum.
  task automatic b_decimate(input logic [6:0] d0, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [6:0] d3,
                            input logic [8:0] expected, input string tag);
    bit seen_early = 1'b0;
    en_b = 1'b1; ready_b = 1'b0; din_b = 7'h7F;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k < 24 && valid_b) seen_early = 1'b1;
      case (k)
        1: begin
          checks_total++; if (pwrdn_b !== 1'b0) $display("FAIL %s_pwrdn got=%b exp=0", tag, pwrdn_b); else checks_passed++;
        end
        8: begin
          checks_total++; if (run_b !== 1'b0) $display("FAIL %s_wake_len got=%b exp=0", tag, run_b); else checks_passed++;
        end
        9: begin
          checks_total++; if (run_b !== 1'b1) $display("FAIL %s_run_entry got=%b exp=1", tag, run_b); else checks_passed++;
        end
        10: din_b = d0;
        14: din_b = d1;
        18: din_b = d2;
        22: din_b = d3;
        default: ;
      endcase
    end
    checks_total++; if (seen_early !== 1'b0) $display("FAIL %s_early_valid got=%b exp=0", tag, seen_early); else checks_passed++;
    checks_total++; if (valid_b !== 1'b1) $display("FAIL %s_valid got=%b exp=1", tag, valid_b); else checks_passed++;
    checks_total++; if (dout_b !== expected) $display("FAIL %s_sum got=%0d exp=%0d", tag, dout_b, expected); else checks_passed++;
  endtask

  task automatic test_decimation();
    b_decimate(7'd10, 7'd20, 7'd30, 7'd40, 9'd100, "dec4");
  endtask

  // Continues from b_decimate (k=24, result held). Two samples of 5 go into
  // the accumulator (added at k=28 and k=32), then the enable drops.
  task automatic test_disable_reenable();
    ready_b = 1'b1; din_b = 7'd5;
    for (int k = 25; k <= 32; k++) begin
      tick();
      if (k == 25) begin
        checks_total++; if (valid_b !== 1'b0) $display("FAIL dis_taken got=%b exp=0", valid_b); else checks_passed++;
      end
    end
    en_b = 1'b0;
    tick();
    checks_total++; if (pwrdn_b !== 1'b1) $display("FAIL dis_pwrdn got=%b exp=1", pwrdn_b); else checks_passed++;
    checks_total++; if (aclk_b !== 1'b0) $display("FAIL dis_adc_clk got=%b exp=0", aclk_b); else checks_passed++;
    checks_total++; if (run_b !== 1'b0) $display("FAIL dis_running got=%b exp=0", run_b); else checks_passed++;
    tick();
    tick();
    b_decimate(7'd1, 7'd2, 7'd3, 7'd4, 9'd10, "reen");
  endtask

  // ---------------------------------------------------------------------------
  // A: WAKE k=1..64, RUN from k=65, captures after odd k, result valid after
  // k=67,69,... and taken the next edge while i_ready=1.
  task automatic test_stream();
    bit seen_early = 1'b0;
    en_a = 1'b1; ready_a = 1'b1; din_a = 7'h55;
    for (int k = 1; k <= 69; k++) begin
      tick();
      if (k < 67 && valid_a) seen_early = 1'b1;
      case (k)
        1: begin
          checks_total++; if (pwrdn_a !== 1'b0) $display("FAIL st_pwrdn got=%b exp=0", pwrdn_a); else checks_passed++;
          checks_total++; if (aclk_a !== 1'b1) $display("FAIL st_adc_clk_hi got=%b exp=1", aclk_a); else checks_passed++;
        end
        2: begin
          checks_total++; if (aclk_a !== 1'b0) $display("FAIL st_adc_clk_lo got=%b exp=0", aclk_a); else checks_passed++;
        end
        64: begin
          checks_total++; if (run_a !== 1'b0) $display("FAIL st_wake_len got=%b exp=0", run_a); else checks_passed++;
        end
        65: begin
          checks_total++; if (run_a !== 1'b1) $display("FAIL st_run_entry got=%b exp=1", run_a); else checks_passed++;
        end
        67: begin
          checks_total++; if (seen_early !== 1'b0) $display("FAIL st_early_valid got=%b exp=0", seen_early); else checks_passed++;
          checks_total++; if (valid_a !== 1'b1) $display("FAIL st_valid1 got=%b exp=1", valid_a); else checks_passed++;
          checks_total++; if (dout_a !== 7'h55) $display("FAIL st_data got=%h exp=55", dout_a); else checks_passed++;
        end
        68: begin
          checks_total++; if (valid_a !== 1'b0) $display("FAIL st_valid_gap got=%b exp=0", valid_a); else checks_passed++;
        end
        69: begin
          checks_total++; if (valid_a !== 1'b1) $display("FAIL st_valid2 got=%b exp=1", valid_a); else checks_passed++;
        end
        default: ;
      endcase
    end
  endtask

  // Continues at k=69. Results land on odd edges; with i_ready low the one
  // at k=71 (data 55) is held and the one at k=73 (data 22) is dropped.
  task automatic test_overflow();
    tick(); // k=70
    checks_total++; if (valid_a !== 1'b0) $display("FAIL ov_pre_valid got=%b exp=0", valid_a); else checks_passed++;
    ready_a = 1'b0; din_a = 7'h22;
    tick(); // k=71
    checks_total++; if (dout_a !== 7'h55) $display("FAIL ov_held_data got=%h exp=55", dout_a); else checks_passed++;
    checks_total++; if (ovf_a !== 1'b0) $display("FAIL ov_not_yet got=%b exp=0", ovf_a); else checks_passed++;
    tick(); // k=72
    tick(); // k=73: drop
    checks_total++; if (ovf_a !== 1'b1) $display("FAIL ov_set got=%b exp=1", ovf_a); else checks_passed++;
    checks_total++; if (valid_a !== 1'b1) $display("FAIL ov_still_valid got=%b exp=1", valid_a); else checks_passed++;
    checks_total++; if (dout_a !== 7'h55) $display("FAIL ov_kept_data got=%h exp=55", dout_a); else checks_passed++;
    clr_a = 1'b1;
    tick(); // k=74: clear, no drop
    checks_total++; if (ovf_a !== 1'b0) $display("FAIL ov_clear got=%b exp=0", ovf_a); else checks_passed++;
    tick(); // k=75: clear together with a drop
    checks_total++; if (ovf_a !== 1'b1) $display("FAIL ov_set_wins got=%b exp=1", ovf_a); else checks_passed++;
    clr_a = 1'b0; ready_a = 1'b1;
    tick(); // k=76: held 55 taken
    checks_total++; if (valid_a !== 1'b0) $display("FAIL ov_taken got=%b exp=0", valid_a); else checks_passed++;
    checks_total++; if (ovf_a !== 1'b1) $display("FAIL ov_sticky got=%b exp=1", ovf_a); else checks_passed++;
    tick(); // k=77: next result flows
    checks_total++; if (dout_a !== 7'h22) $display("FAIL ov_resume_data got=%h exp=22", dout_a); else checks_passed++;
  endtask

  // Continues at k=77 with o_valid=1 and o_overflow=1; enable stays high.
  task automatic test_reset_mid_run();
    ready_a = 1'b0;
    rst = 1'b1;
    tick();
    checks_total++; if (pwrdn_a !== 1'b1) $display("FAIL rr_pwrdn got=%b exp=1", pwrdn_a); else checks_passed++;
    checks_total++; if (aclk_a !== 1'b0) $display("FAIL rr_adc_clk got=%b exp=0", aclk_a); else checks_passed++;
    checks_total++; if (valid_a !== 1'b0) $display("FAIL rr_valid got=%b exp=0", valid_a); else checks_passed++;
    checks_total++; if (dout_a !== 7'h00) $display("FAIL rr_data got=%h exp=00", dout_a); else checks_passed++;
    checks_total++; if (ovf_a !== 1'b0) $display("FAIL rr_overflow got=%b exp=0", ovf_a); else checks_passed++;
    checks_total++; if (run_a !== 1'b0) $display("FAIL rr_running got=%b exp=0", run_a); else checks_passed++;
    rst = 1'b0;
    en_a = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_twos_comp();
    test_decimation();
    test_disable_reenable();
    test_stream();
    test_overflow();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule : tb_adc_par_capture
